// File: rtl/apu_pkg.sv
// Shared types and constants for the APU responder model: op codes, queue entry
// layout, flag bit positions and the integer op datapath.
package apu_pkg;

  localparam int APU_NARGS    = 3;
  localparam int APU_WOP      = 6;
  localparam int APU_NDSFLAGS = 15;
  localparam int APU_NUSFLAGS = 6;
  localparam int APU_WDATA    = 32;
  localparam int APU_WTIMER   = 4;

  localparam int FLAG_ZERO    = 0;
  localparam int FLAG_ILLEGAL = 1;
  localparam int FLAG_ECHO_LO = 2;
  localparam int FLAG_ECHO_HI = 5;

  typedef enum logic [APU_WOP-1:0] {
    APU_ADD = 6'd0,
    APU_SUB = 6'd1,
    APU_AND = 6'd2,
    APU_OR  = 6'd3,
    APU_XOR = 6'd4,
    APU_MUL = 6'd5,
    APU_MAC = 6'd6
  } apu_op_e;

  typedef struct packed {
    logic [APU_WDATA-1:0]    result;
    logic [APU_NUSFLAGS-1:0] flags;
    logic [APU_WTIMER-1:0]   timer;
  } apu_entry_t;

  function automatic apu_entry_t apu_exec(
    input logic [APU_WOP-1:0]                 op,
    input logic [APU_WDATA-1:0]               a,
    input logic [APU_WDATA-1:0]               b,
    input logic [APU_WDATA-1:0]               c,
    input logic [FLAG_ECHO_HI-FLAG_ECHO_LO:0] echo
  );
    apu_entry_t e;
    logic       illegal;
    e       = '0;
    illegal = 1'b0;
    case (op)
      APU_ADD: e.result = a + b;
      APU_SUB: e.result = a - b;
      APU_AND: e.result = a & b;
      APU_OR:  e.result = a | b;
      APU_XOR: e.result = a ^ b;
      APU_MUL: e.result = a * b;
      APU_MAC: e.result = a * b + c;
      default: begin
        e.result = '0;
        illegal  = 1'b1;
      end
    endcase
    e.flags[FLAG_ZERO]                 = (e.result == '0);
    e.flags[FLAG_ILLEGAL]              = illegal;
    e.flags[FLAG_ECHO_HI:FLAG_ECHO_LO] = echo;
    return e;
  endfunction

endpackage

// File: rtl/apu_resp_queue.sv
// In-order response queue: circular buffer of {result, flags, timer}; every
// entry's timer counts down each cycle and the head may leave once it hits 0.
module apu_resp_queue
  import apu_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push_i,
  input  apu_entry_t    push_entry_i,
  input  logic          pop_i,
  output apu_entry_t    head_o,
  output logic          head_ready_o,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  output logic          empty_o
);

  apu_entry_t    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          push_ok, pop_ok;

  assign full_o       = (count_q == CW'(DEPTH));
  assign empty_o      = (count_q == '0);
  assign push_ok      = push_i && !full_o;
  assign pop_ok       = pop_i && !empty_o;
  assign head_o       = mem_q[rd_ptr_q];
  assign head_ready_o = !empty_o && (mem_q[rd_ptr_q].timer == '0);
  assign count_o      = count_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        if (mem_q[i].timer != '0) mem_q[i].timer <= mem_q[i].timer - 1'b1;
      // a freshly pushed entry overrides the decrement of its slot
      if (push_ok) begin
        mem_q[wr_ptr_q] <= push_entry_i;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop_ok) rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/apu_responder_model.sv
// Responder end of the APU interface: grants while the queue has room, computes
// the result at accept time and returns it in order after a fixed latency.
module apu_responder_model
  import apu_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int LATENCY = 3
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic                                 apu_req_i,
  output logic                                 apu_gnt_o,
  input  logic [APU_NARGS-1:0][APU_WDATA-1:0]  apu_operands_i,
  input  logic [APU_WOP-1:0]                   apu_op_i,
  input  logic [APU_NDSFLAGS-1:0]              apu_flags_i,
  output logic                                 apu_rvalid_o,
  output logic [APU_WDATA-1:0]                 apu_result_o,
  output logic [APU_NUSFLAGS-1:0]              apu_flags_o,
  output logic                                 busy_o
);

  localparam int CW = $clog2(DEPTH + 1);
  // Timer holds the cycles left before the pop decision; the registered
  // response stage adds the final cycle.
  localparam logic [APU_WTIMER-1:0] TIMER_INIT =
    (LATENCY >= 2) ? APU_WTIMER'(LATENCY - 2) : '0;
  // With a one-cycle latency an accept into an empty queue must skip the queue.
  localparam bit BYPASS_EN = (LATENCY == 1);

  apu_entry_t              req_entry, head;
  logic                    full, empty, head_ready;
  logic [CW-1:0]           count;
  logic                    bypass, push, pop;
  logic                    rvalid_d, rvalid_q;
  logic [APU_WDATA-1:0]    result_d, result_q;
  logic [APU_NUSFLAGS-1:0] flags_d, flags_q;
  logic [12:0]             unused_flags;
  logic [APU_WTIMER-1:0]   unused_head_timer;

  assign unused_flags      = {apu_flags_i[14:6], apu_flags_i[1:0], 2'b00};
  assign unused_head_timer = head.timer;

  always_comb begin
    req_entry = apu_exec(apu_op_i, apu_operands_i[0], apu_operands_i[1],
                         apu_operands_i[2], apu_flags_i[FLAG_ECHO_HI:FLAG_ECHO_LO]);
    req_entry.timer = TIMER_INIT;
  end

  assign apu_gnt_o = apu_req_i && !full;
  assign bypass    = apu_gnt_o && BYPASS_EN && empty;
  assign push      = apu_gnt_o && !bypass;
  assign pop       = head_ready;

  apu_resp_queue #(.DEPTH(DEPTH)) u_queue (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .push_i       (push),
    .push_entry_i (req_entry),
    .pop_i        (pop),
    .head_o       (head),
    .head_ready_o (head_ready),
    .count_o      (count),
    .full_o       (full),
    .empty_o      (empty)
  );

  always_comb begin
    rvalid_d = bypass || pop;
    result_d = result_q;
    flags_d  = flags_q;
    if (bypass) begin
      result_d = req_entry.result;
      flags_d  = req_entry.flags;
    end else if (pop) begin
      result_d = head.result;
      flags_d  = head.flags;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rvalid_q <= 1'b0;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      rvalid_q <= rvalid_d;
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

  assign apu_rvalid_o = rvalid_q;
  assign apu_result_o = result_q;
  assign apu_flags_o  = flags_q;
  assign busy_o       = (count != '0) || rvalid_q;

endmodule

// File: tb/tb_apu_responder_model.sv
// Scoreboard bench for apu_responder_model: expected result, flags and response
// cycle are queued at grant time and matched against every rvalid pulse.
module tb_apu_responder_model;
  localparam int LAT  = 3;
  localparam int LATF = 6;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             req, gnt, rvalid, busy;
  logic [2:0][31:0] opnds;
  logic [5:0]       op;
  logic [14:0]      fl;
  logic [31:0]      result;
  logic [5:0]       rflags;

  logic             req_f, gnt_f, rvalid_f, busy_f;
  logic [31:0]      a_f, result_f;
  logic [5:0]       rflags_f;
  logic [2:0][31:0] opnds_f;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int last_exp = -1;

  typedef struct {
    logic [31:0] res;
    logic [5:0]  fl;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign opnds_f = {32'd0, 32'd100, a_f};

  apu_responder_model #(.DEPTH(4), .LATENCY(LAT)) dut (
    .clk_i(clk), .rst_ni(rst_n), .apu_req_i(req), .apu_gnt_o(gnt),
    .apu_operands_i(opnds), .apu_op_i(op), .apu_flags_i(fl),
    .apu_rvalid_o(rvalid), .apu_result_o(result), .apu_flags_o(rflags),
    .busy_o(busy));

  apu_responder_model #(.DEPTH(4), .LATENCY(LATF)) u_fill (
    .clk_i(clk), .rst_ni(rst_n), .apu_req_i(req_f), .apu_gnt_o(gnt_f),
    .apu_operands_i(opnds_f), .apu_op_i(6'd0), .apu_flags_i(15'd0),
    .apu_rvalid_o(rvalid_f), .apu_result_o(result_f), .apu_flags_o(rflags_f),
    .busy_o(busy_f));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic exp_t model(input logic [5:0] o, input logic [31:0] a,
                                 input logic [31:0] b, input logic [31:0] c,
                                 input logic [14:0] f);
    exp_t e;
    logic ill;
    ill = 1'b0;
    case (o)
      6'd0: e.res = a + b;
      6'd1: e.res = a - b;
      6'd2: e.res = a & b;
      6'd3: e.res = a | b;
      6'd4: e.res = a ^ b;
      6'd5: e.res = a * b;
      6'd6: e.res = a * b + c;
      default: begin e.res = 32'd0; ill = 1'b1; end
    endcase
    e.fl  = {f[5:2], ill, (e.res == 32'd0)};
    e.cyc = 0;
    return e;
  endfunction

  // response monitor: every pulse must match the head of the scoreboard
  always @(negedge clk) begin
    if (rst_n) begin
      if (rvalid) begin
        if (sb.size() == 0) chk("spurious_rvalid", 64'(rvalid), 64'd0);
        else begin
          exp_t e;
          e = sb.pop_front();
          chk("result", 64'(result), 64'(e.res));
          chk("flags", 64'(rflags), 64'(e.fl));
          chk("rsp_cycle", 64'(cyc), 64'(e.cyc));
        end
      end else if (sb.size() > 0 && sb[0].cyc <= cyc) begin
        void'(sb.pop_front());
        chk("missing_rvalid", 64'(rvalid), 64'd1);
      end
    end
  end

  task automatic send(input logic [5:0] o, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] c, input logic [14:0] f);
    bit granted;
    exp_t e;
    granted = 1'b0;
    @(negedge clk);
    req = 1'b1; op = o; opnds = {c, b, a}; fl = f;
    for (int w = 0; w < 50; w++) begin
      #4;
      if (gnt) begin
        e = model(o, a, b, c, f);
        e.cyc = (cyc + LAT > last_exp + 1) ? cyc + LAT : last_exp + 1;
        last_exp = e.cyc;
        sb.push_back(e);
        granted = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!granted) chk("gnt_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1 req = 1'b0;
  endtask

  task automatic drain();
    for (int w = 0; w < 100 && sb.size() > 0; w++) @(negedge clk);
    if (sb.size() > 0) begin
      chk("drain_timeout", 64'(sb.size()), 64'd0);
      sb.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    int gi, ridx;
    logic [5:0]  ro;
    logic [31:0] ra, rb, rc;
    rst_n = 1'b0; req = 1'b0; op = '0; opnds = '0; fl = '0;
    req_f = 1'b0; a_f = '0;
    repeat (2) @(negedge clk);
    chk("rst_rvalid", 64'(rvalid), 64'd0);
    chk("rst_result", 64'(result), 64'd0);
    chk("rst_flags", 64'(rflags), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_busy_f", 64'(busy_f), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    send(6'd0, 32'd5, 32'd7, 32'd0, 15'd0);
    chk("busy_pending", 64'(busy), 64'd1);
    drain();
    chk("busy_idle", 64'(busy), 64'd0);
    send(6'd1, 32'h1234, 32'h1234, 32'd0, 15'd0);
    send(6'd6, 32'd3, 32'd4, 32'hFFFF_FFF4, 15'd0);
    drain();
    send(6'h3F, 32'd9, 32'd9, 32'd9, 15'h7FFF);
    send(6'd0, 32'd1, 32'd2, 32'd0, 15'h0014);
    drain();
    send(6'd2, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'd0, 15'h0004);
    send(6'd3, 32'hF000_0000, 32'h0000_000F, 32'd0, 15'h0008);
    send(6'd4, 32'hAAAA_AAAA, 32'hAAAA_AAAA, 32'd0, 15'h0020);
    send(6'd5, 32'h0001_0001, 32'h0001_0001, 32'd0, 15'h0000);
    drain();

    // reset with responses outstanding
    send(6'd0, 32'd1, 32'd1, 32'd0, 15'd0);
    send(6'd0, 32'd2, 32'd2, 32'd0, 15'd0);
    send(6'd0, 32'd3, 32'd3, 32'd0, 15'd0);
    chk("pre_rst_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_rvalid", 64'(rvalid), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    sb.delete();
    last_exp = -1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("post_rst_quiet", 64'(rvalid), 64'd0);
    end
    send(6'd0, 32'd40, 32'd2, 32'd0, 15'd0);
    drain();

    // fill/stall on the long-latency instance
    gi = 0; ridx = 0;
    @(negedge clk);
    for (int k = 0; k < 14; k++) begin
      chk("fill_rvalid", 64'(rvalid_f), 64'((k >= 6 && k <= 9) || k == 12));
      if (rvalid_f) begin
        chk("fill_result", 64'(result_f), 64'(100 + ridx));
        chk("fill_flags", 64'(rflags_f), 64'd0);
        ridx++;
      end
      req_f = (gi < 5);
      a_f = 32'(gi);
      #4;
      chk("fill_gnt", 64'(gnt_f), 64'(k < 4 || k == 6));
      if (gnt_f) gi++;
      @(negedge clk);
    end
    req_f = 1'b0;
    chk("fill_busy_idle", 64'(busy_f), 64'd0);

    for (int i = 0; i < 10000; i++) begin
      ro = ($urandom_range(0, 9) > 6) ? 6'($urandom_range(7, 63)) : 6'($urandom_range(0, 6));
      ra = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      rc = $urandom;
      repeat ($urandom_range(0, 3)) @(posedge clk);
      send(ro, ra, rb, rc, 15'($urandom));
    end
    drain();
    chk("final_busy", 64'(busy), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
